palette_arbiter: RTL

PALETTE_ARBITER -- requirements
Module: palette_arbiter

---
 rtl/pal_arb_pkg.sv | 23 ++
 rtl/pal_wbuf.sv | 44 ++++
 rtl/palette_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pal_arb_pkg.sv
// rtl/pal_arb_pkg.sv - shared grant encoding, widths and write-buffer entry type for palette_arbiter
package pal_arb_pkg;

  localparam int PAL_AW         = 6;
  localparam int PAL_DW         = 32;
  localparam int PAL_BEW        = 4;
  localparam int PAL_WBUF_DEPTH = 4;

  typedef enum logic [2:0] {
    GNT_IDLE   = 3'd0,
    GNT_VID    = 3'd1,
    GNT_CPU_RD = 3'd2,
    GNT_CPU_WR = 3'd3,
    GNT_WBUF   = 3'd4
  } gnt_t;

  typedef struct packed {
    logic [PAL_AW-1:0]  addr;
    logic [PAL_BEW-1:0] be;
    logic [PAL_DW-1:0]  data;
  } wbuf_entry_t;

endpackage

// File: rtl/pal_wbuf.sv
// rtl/pal_wbuf.sv - small posted-write FIFO holding {address, byteenable, data} for the palette RAM
module pal_wbuf
  import pal_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  wbuf_entry_t push_entry,
  input  logic        pop,
  output wbuf_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(PAL_WBUF_DEPTH);

  wbuf_entry_t    mem [PAL_WBUF_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;

  // Pointer and occupancy tracking; reset empties the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(PAL_WBUF_DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/palette_arbiter.sv
// rtl/palette_arbiter.sv - single-port palette RAM arbiter (scanout vs CPU), optional write buffer via PAL_WBUF_EN
module palette_arbiter
  import pal_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vid_req,
  input  logic [PAL_AW-1:0]  vid_idx,
  output logic               vid_valid,
  output logic [PAL_DW-1:0]  vid_data,
  output logic               vid_miss,
  input  logic               cpu_chipselect,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [PAL_AW-1:0]  cpu_address,
  input  logic [PAL_BEW-1:0] cpu_byteenable,
  input  logic [PAL_DW-1:0]  cpu_writedata,
  output logic               cpu_waitrequest,
  output logic [PAL_DW-1:0]  cpu_readdata,
  output logic               cpu_readdatavalid,
  output logic [PAL_AW-1:0]  ram_address,
  output logic [PAL_BEW-1:0] ram_byteenable,
  output logic [PAL_DW-1:0]  ram_writedata,
  output logic               ram_wren,
  output logic               ram_clken,
  input  logic [PAL_DW-1:0]  ram_readdata
);

  localparam int             CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  gnt_t          gnt;
  gnt_t          last_gnt;
  logic [CW-1:0] starve_cnt;
  logic          cpu_rd;
  logic          cpu_wr;
  logic          cpu_pending;
  logic          force_cpu;
  logic          cpu_accept;

  // A simultaneous read+write is treated as a write.
  assign cpu_wr      = cpu_chipselect & cpu_write;
  assign cpu_rd      = cpu_chipselect & cpu_read & ~cpu_write;
  assign cpu_pending = cpu_rd | cpu_wr;
  assign force_cpu   = reset_n & cpu_pending & (starve_cnt == LIMIT);

`ifdef PAL_WBUF_EN
  wbuf_entry_t wb_in;
  wbuf_entry_t wb_head;
  logic        wb_full;
  logic        wb_empty;
  logic        wb_push;
  logic        wb_pop;

  assign wb_in   = '{addr: cpu_address, be: cpu_byteenable, data: cpu_writedata};
  assign wb_push = reset_n & cpu_wr & ~wb_full;
  assign wb_pop  = (gnt == GNT_WBUF);

  pal_wbuf u_wbuf (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (wb_push),
    .push_entry (wb_in),
    .pop        (wb_pop),
    .head       (wb_head),
    .full       (wb_full),
    .empty      (wb_empty)
  );

  // Grant: writes post into the buffer; reads wait for it to drain so order is kept.
  always_comb begin
    gnt = GNT_IDLE;
    if (!reset_n)                                gnt = GNT_IDLE;
    else if (force_cpu && cpu_rd && wb_empty)    gnt = GNT_CPU_RD;
    else if (force_cpu && !wb_empty)             gnt = GNT_WBUF;
    else if (vid_req)                            gnt = GNT_VID;
    else if (cpu_rd && wb_empty)                 gnt = GNT_CPU_RD;
    else if (!wb_empty)                          gnt = GNT_WBUF;
  end

  assign cpu_accept = (gnt == GNT_CPU_RD) | wb_push;
`else
  // Grant: scanout first unless the CPU has starved, then read, then write.
  always_comb begin
    gnt = GNT_IDLE;
    if (!reset_n)       gnt = GNT_IDLE;
    else if (force_cpu) gnt = cpu_rd ? GNT_CPU_RD : GNT_CPU_WR;
    else if (vid_req)   gnt = GNT_VID;
    else if (cpu_rd)    gnt = GNT_CPU_RD;
    else if (cpu_wr)    gnt = GNT_CPU_WR;
  end

  assign cpu_accept = (gnt == GNT_CPU_RD) | (gnt == GNT_CPU_WR);
`endif

  // RAM port steering for whichever source owns this cycle.
  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    case (gnt)
      GNT_VID: begin
        ram_address    = vid_idx;
        ram_byteenable = '1;
      end
      GNT_CPU_RD: begin
        ram_address    = cpu_address;
        ram_byteenable = '1;
      end
      GNT_CPU_WR: begin
        ram_address    = cpu_address;
        ram_byteenable = cpu_byteenable;
        ram_writedata  = cpu_writedata;
      end
`ifdef PAL_WBUF_EN
      GNT_WBUF: begin
        ram_address    = wb_head.addr;
        ram_byteenable = wb_head.be;
        ram_writedata  = wb_head.data;
      end
`endif
      default: ;
    endcase
  end

  // Remember who owned the RAM so next cycle's q goes to the right requester.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_gnt <= GNT_IDLE;
    else          last_gnt <= gnt;
  end

  // Starvation counter: counts denied CPU cycles, saturates, clears on accept or forced grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               starve_cnt <= '0;
    else if (force_cpu || cpu_accept)           starve_cnt <= '0;
    else if (cpu_pending && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
  end

  assign cpu_waitrequest   = cpu_pending & ~cpu_accept;
  assign vid_miss          = reset_n & vid_req & (gnt != GNT_VID);
  assign ram_wren          = (gnt == GNT_CPU_WR) | (gnt == GNT_WBUF);
  assign ram_clken         = reset_n;
  assign vid_valid         = (last_gnt == GNT_VID);
  assign vid_data          = vid_valid ? ram_readdata : '0;
  assign cpu_readdatavalid = (last_gnt == GNT_CPU_RD);
  assign cpu_readdata      = cpu_readdatavalid ? ram_readdata : '0;

endmodule
